// File: rtl/serial_word_arb_pkg.sv
// Shared types and helpers for the serial word arbiter.
// Holds the FSM state encoding and the requester-ID width rule.
package serial_word_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A single requester still needs a one-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_word_arbiter_rr_picker.sv
// Round-robin winner search: first set request after last_grant, wrapping around.
// Latency: purely combinational, no state.
// Backpressure: none; caller decides when the result is used.
module rr_picker
    import serial_word_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic             found,
    output logic [IDW-1:0]   winner
);

    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        // Offset 1..N_REQ so last_grant itself is considered last.
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_grant) + i) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/serial_word_arbiter.sv
// Round-robin arbiter sharing one LSB-first serial-to-parallel assembler among N_REQ lanes.
// Latency: 1 cycle to grant; word appears 1 cycle after its last accepted bit; back-to-back words have no bubble.
// Backpressure: stalls while the granted lane is not valid; SERIAL_WORD_ARB_TIMEOUT_EN bounds that stall with an abort.
module serial_word_arbiter
    import serial_word_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16,
    localparam int IDW    = id_width(N_REQ),
    localparam int CW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_data,
    output logic [N_REQ-1:0] req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDW-1:0]   out_id,
    output logic             abort
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_d;
    logic [IDW-1:0]   out_id_d;
    logic             rearb;
    logic             pick_found;
    logic [IDW-1:0]   pick_winner;
    logic [IDW-1:0]   pick_ptr;

`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0]   idle_q, idle_d;
    logic             abort_q, abort_d;
    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    // While busy, re-arbitration starts after the current owner.
    assign pick_ptr = (state_q == BUSY) ? grant_q : last_q;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_picker (
        .req        (req_valid),
        .last_grant (pick_ptr),
        .found      (pick_found),
        .winner     (pick_winner)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data;
        out_id_d    = out_id;
        rearb       = 1'b0;
        req_ready   = '0;
`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
        idle_d      = idle_q;
        abort_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d   = BUSY;
                    grant_d   = pick_winner;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
                    idle_d    = '0;
`endif
                end
            end
            BUSY: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    shreg_d[bit_cnt_q] = req_data[grant_q];
`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
                    idle_d = '0;
`endif
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = shreg_d;
                        out_id_d    = grant_q;
                        rearb       = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else begin
`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
                    if (idle_q == TCW'(TIMEOUT - 1)) begin
                        abort_d = 1'b1;
                        rearb   = 1'b1;
                    end else begin
                        idle_d = idle_q + TCW'(1);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Word finished or dropped: hand over without a bubble if anyone is waiting.
        if (rearb) begin
            last_d    = grant_q;
            bit_cnt_d = '0;
            shreg_d   = '0;
`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
            idle_d    = '0;
`endif
            if (pick_found) begin
                state_d = BUSY;
                grant_d = pick_winner;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= IDW'(N_REQ - 1);
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
            idle_q    <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_id    <= out_id_d;
`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
            idle_q    <= idle_d;
            abort_q   <= abort_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_word_arbiter.sv
// Randomized and directed bench for serial_word_arbiter against a word-level reference model.
module tb_serial_word_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int T   = 16;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           abort;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_word_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .TIMEOUT (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .abort     (abort)
    );

    // Reference model: owner index, bits collected so far, word built arithmetically.
    bit           m_busy;
    int           m_g, m_cnt, m_last, m_idle, m_oid;
    logic [W-1:0] m_word, m_od;
    bit           m_ov, m_ab;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rv, input int last);
        for (int i = 1; i <= N; i++) begin
            if (rv[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        return m_busy ? N'(1 << m_g) : '0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_cnt = 0; m_last = N - 1; m_idle = 0;
        m_word = '0; m_od = '0; m_oid = 0; m_ov = 0; m_ab = 0;
    endtask

    task automatic finish_word(input logic [N-1:0] rv);
        m_last = m_g;
        m_cnt  = 0;
        m_word = '0;
        m_idle = 0;
        if (rv != 0) m_g = pick(rv, m_last);
        else         m_busy = 0;
    endtask

    task automatic model_step(input logic [N-1:0] rv, input logic [N-1:0] rd);
        m_ov = 0;
        m_ab = 0;
        if (!m_busy) begin
            if (rv != 0) begin
                m_g = pick(rv, m_last); m_busy = 1; m_cnt = 0; m_word = '0; m_idle = 0;
            end
        end else if (rv[m_g]) begin
            m_word = m_word | (W'(rd[m_g]) << m_cnt);
            m_cnt++;
            m_idle = 0;
            if (m_cnt == W) begin
                m_ov = 1; m_od = m_word; m_oid = m_g;
                finish_word(rv);
            end
        end else begin
            m_idle++;
`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
            if (m_idle == T) begin
                m_ab = 1;
                finish_word(rv);
            end
`endif
        end
    endtask

    // Called at a negedge; returns at the following negedge after checking outputs.
    task automatic tick(input logic [N-1:0] rv, input logic [N-1:0] rd);
        req_valid = rv;
        req_data  = rd;
        check("req_ready", req_ready, exp_ready());
        model_step(rv, rd);
        @(posedge clk);
        @(negedge clk);
        check("out_valid", out_valid, m_ov);
        check("out_data", out_data, m_od);
        check("out_id", out_id, m_oid);
        check("abort", abort, m_ab);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_abort", abort, 0);
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [N-1:0] rd;
        int           wc;
        bit           done;

        rst = 1'b1; req_valid = '0; req_data = '0;
        @(negedge clk);
        do_reset();

        // Lane 2 sends 1,0,1,1,0,0,1,0 first to last.
        pat  = 8'h4D;
        done = 0;
        tick('0, '0);
        for (int c = 0; c < 30 && !done; c++) begin
            rd = '0;
            rd[2] = pat[m_busy ? m_cnt : 0];
            tick(4'b0100, rd);
            if (m_ov) done = 1;
        end
        check("t1_done", done, 1);
        check("t1_data", out_data, 8'h4D);
        check("t1_id", out_id, 2);
        tick('0, '0);

        // Lanes 0 and 1 always valid: grants alternate.
        do_reset();
        wc = 0;
        for (int c = 0; c < 100 && wc < 4; c++) begin
            tick(4'b0011, 4'($urandom));
            if (m_ov) begin
                check("t2_alt_id", out_id, wc % 2);
                wc++;
            end
        end
        check("t2_words", wc, 4);

        // Lane 3 stalls mid-word while lane 0 waits.
        do_reset();
        for (int c = 0; c < 20 && !(m_busy && m_cnt == 4); c++) tick(4'b1000, 4'($urandom));
        repeat (5) tick(4'b0001, 4'($urandom));
        check("t3_hold", req_ready, 4'b1000);
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick(4'b1001, 4'($urandom));
            if (m_ov) done = 1;
        end
        check("t3_done", done, 1);
        check("t3_id", out_id, 3);

        // Reset in the middle of a word.
        do_reset();
        for (int c = 0; c < 20 && !(m_busy && m_cnt == 4); c++) tick(4'b0100, 4'b0100);
        do_reset();
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick(4'b0101, 4'($urandom));
            if (m_ov) done = 1;
        end
        check("t4_done", done, 1);
        check("t4_id", out_id, 0);

        // Lane 1 alone: three words in exactly 1 + 3*W cycles.
        do_reset();
        wc = 0;
        for (int c = 0; c < 1 + 3 * W; c++) begin
            tick(4'b0010, 4'($urandom));
            if (m_ov) begin
                check("t5_id", out_id, 1);
                wc++;
            end
        end
        check("t5_words", wc, 3);

`ifdef SERIAL_WORD_ARB_TIMEOUT_EN
        // Granted lane goes silent long enough to be dropped.
        do_reset();
        for (int c = 0; c < 20 && !(m_busy && m_cnt == 3); c++) tick(4'b0100, 4'($urandom));
        wc = 0;
        for (int c = 0; c < T + 2; c++) begin
            tick(4'b0001, 4'($urandom));
            if (abort) wc++;
            check("t6_no_word", out_valid, 0);
        end
        check("t6_aborts", wc, 1);
        check("t6_new_grant", req_ready, 4'b0001);
`endif

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick(4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
